// File: rtl/alu_pkg.sv
// Shared opcode, slice-op and state definitions for the bit-serial ALU sequencer.
// Includes the opcode-to-slice-control decode.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [1:0] SOP_AND  = 2'b00;
    localparam logic [1:0] SOP_OR   = 2'b01;
    localparam logic [1:0] SOP_ADD  = 2'b10;
    localparam logic [1:0] SOP_LESS = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic       a_inv;
        logic       b_inv;
        logic [1:0] op;
        logic       arith;
        logic       slt;
        logic       legal;
    } slice_ctrl_t;

    // Illegal opcodes still run the full latency as a harmless AND; result is forced to 0 at the end.
    function automatic slice_ctrl_t alu_decode(input logic [3:0] opc);
        slice_ctrl_t c;
        c = '{a_inv: 1'b0, b_inv: 1'b0, op: SOP_AND, arith: 1'b0, slt: 1'b0, legal: 1'b1};
        case (opc)
            ALU_AND: c.op = SOP_AND;
            ALU_OR:  c.op = SOP_OR;
            ALU_ADD: begin c.op = SOP_ADD; c.arith = 1'b1; end
            ALU_SUB: begin c.op = SOP_ADD; c.arith = 1'b1; c.b_inv = 1'b1; end
            ALU_SLT: begin c.op = SOP_ADD; c.arith = 1'b1; c.b_inv = 1'b1; c.slt = 1'b1; end
            ALU_NOR: begin c.op = SOP_AND; c.a_inv = 1'b1; c.b_inv = 1'b1; end
            default: c.legal = 1'b0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_top.sv
// 1-bit ALU slice: AND / OR / full-add / less pass-through with optional operand inversion.
// Purely combinational, zero latency.
// No flow control; the caller sequences it.
module alu_top (
    input  logic       src1,
    input  logic       src2,
    input  logic       less,
    input  logic       A_invert,
    input  logic       B_invert,
    input  logic       cin,
    input  logic [1:0] operation,
    output logic       result,
    output logic       cout
);
    logic a;
    logic b;

    assign a    = src1 ^ A_invert;
    assign b    = src2 ^ B_invert;
    assign cout = (a & b) | (a & cin) | (b & cin);

    always_comb begin
        result = 1'b0;
        case (operation)
            2'b00:   result = a & b;
            2'b01:   result = a | b;
            2'b10:   result = a ^ b ^ cin;
            default: result = less;
        endcase
    end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU sequencer around one alu_top slice, LSB first; optional abort via ALU_SERIAL_ABORT_EN.
// Latency: accept at edge k, out_valid high after edge k+WIDTH; issue interval WIDTH+2.
// Backpressure: out_ready low holds DONE with all outputs frozen; in_ready only in IDLE.
module alu_serial_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic [3:0]       ALU_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             cout,
`ifdef ALU_SERIAL_ABORT_EN
    input  logic             abort,
`endif
    output logic             overflow
);
    import alu_pkg::*;

    localparam int IDX_W = $clog2(WIDTH);

    state_e             state_q,    state_d;
    logic [IDX_W-1:0]   idx_q,      idx_d;
    logic [WIDTH-1:0]   a_sh_q,     a_sh_d;
    logic [WIDTH-1:0]   b_sh_q,     b_sh_d;
    logic [WIDTH-2:0]   res_sh_q,   res_sh_d;
    slice_ctrl_t        ctrl_q,     ctrl_d;
    logic               carry_q,    carry_d;
    logic [WIDTH-1:0]   result_q,   result_d;
    logic               cout_q,     cout_d;
    logic               overflow_q, overflow_d;

    logic               slice_res;
    logic               slice_cout;
    logic               last_bit;
    logic               ovf_raw;
    logic [WIDTH-1:0]   full_res;
    slice_ctrl_t        dec;

    alu_top u_slice (
        .src1      (a_sh_q[0]),
        .src2      (b_sh_q[0]),
        .less      (1'b0),
        .A_invert  (ctrl_q.a_inv),
        .B_invert  (ctrl_q.b_inv),
        .cin       (carry_q),
        .operation (ctrl_q.op),
        .result    (slice_res),
        .cout      (slice_cout)
    );

    assign dec      = alu_decode(ALU_control);
    assign last_bit = (idx_q == IDX_W'(WIDTH - 1));
    assign ovf_raw  = carry_q ^ slice_cout;
    assign full_res = {slice_res, res_sh_q};

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        a_sh_d     = a_sh_q;
        b_sh_d     = b_sh_q;
        res_sh_d   = res_sh_q;
        ctrl_d     = ctrl_q;
        carry_d    = carry_q;
        result_d   = result_q;
        cout_d     = cout_q;
        overflow_d = overflow_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_sh_d  = src1;
                    b_sh_d  = src2;
                    ctrl_d  = dec;
                    idx_d   = '0;
                    // Subtraction is the only case that starts with carry-in set (two's complement +1).
                    carry_d = dec.arith & dec.b_inv;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
`ifdef ALU_SERIAL_ABORT_EN
                if (abort) begin
                    state_d = S_IDLE;
                end else
`endif
                begin
                    a_sh_d   = a_sh_q >> 1;
                    b_sh_d   = b_sh_q >> 1;
                    res_sh_d = full_res[WIDTH-1:1];
                    carry_d  = slice_cout;
                    idx_d    = idx_q + 1'b1;
                    if (last_bit) begin
                        state_d    = S_DONE;
                        result_d   = '0;
                        cout_d     = 1'b0;
                        overflow_d = 1'b0;
                        if (!ctrl_q.legal) begin
                            result_d = '0;
                        end else if (ctrl_q.slt) begin
                            // Signed less-than: sign of the difference corrected by overflow.
                            result_d[0] = slice_res ^ ovf_raw;
                        end else begin
                            result_d = full_res;
                            if (ctrl_q.arith) begin
                                cout_d     = slice_cout;
                                overflow_d = ovf_raw;
                            end
                        end
                    end
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            a_sh_q     <= '0;
            b_sh_q     <= '0;
            res_sh_q   <= '0;
            ctrl_q     <= '0;
            carry_q    <= 1'b0;
            result_q   <= '0;
            cout_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            a_sh_q     <= a_sh_d;
            b_sh_q     <= b_sh_d;
            res_sh_q   <= res_sh_d;
            ctrl_q     <= ctrl_d;
            carry_q    <= carry_d;
            result_q   <= result_d;
            cout_q     <= cout_d;
            overflow_q <= overflow_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign zero      = ~|result_q;
    assign cout      = cout_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Self-checking bench for alu_serial_ctrl: directed corner cases plus random ops against an arithmetic model.
module tb_alu_serial_ctrl;
    import alu_pkg::*;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  src1;
    logic [W-1:0]  src2;
    logic [3:0]    ALU_control;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic          zero;
    logic          cout;
    logic          overflow;
`ifdef ALU_SERIAL_ABORT_EN
    logic          abort;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_serial_ctrl #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .src1        (src1),
        .src2        (src2),
        .ALU_control (ALU_control),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .zero        (zero),
        .cout        (cout),
`ifdef ALU_SERIAL_ABORT_EN
        .abort       (abort),
`endif
        .overflow    (overflow)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: {overflow, cout, result} from plain wide arithmetic.
    function automatic logic [W+1:0] model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0]   s;
        logic [W-1:0] r;
        logic         c;
        logic         v;
        r = '0; c = 1'b0; v = 1'b0; s = '0;
        case (op)
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            ALU_NOR: r = ~(a | b);
            ALU_ADD: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[W-1:0]; c = s[W];
                v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            ALU_SUB: begin
                s = {1'b0, a} + {1'b0, ~b} + 1;
                r = s[W-1:0]; c = s[W];
                v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            end
            ALU_SLT: r = ($signed(a) < $signed(b)) ? 1 : 0;
            default: r = '0;
        endcase
        return {v, c, r};
    endfunction

    // Called with the accept edge still ahead; checks latency, outputs, optional stall, handshake.
    task automatic finish_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                             input string tag, input int hold);
        logic [W+1:0] e;
        int n;
        e = model(op, a, b);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            src1 = $urandom; src2 = $urandom; ALU_control = 4'($urandom);
            in_valid = 1'($urandom);
            @(posedge clk); n++; #1;
        end
        chk({tag, ".latency"}, 64'(n), 64'(W));
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, ".result"}, 64'(result), 64'(e[W-1:0]));
        chk({tag, ".cout"}, 64'(cout), 64'(e[W]));
        chk({tag, ".ovf"}, 64'(overflow), 64'(e[W+1]));
        chk({tag, ".zero"}, 64'(zero), 64'(e[W-1:0] == '0));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            in_valid = (i == 2);
            src1 = 32'h1234_5678; src2 = 32'h1111_1111; ALU_control = ALU_ADD;
            @(posedge clk); #1;
            chk({tag, ".hold_vld"}, 64'(out_valid), 64'd1);
            chk({tag, ".hold_rdy"}, 64'(in_ready), 64'd0);
            chk({tag, ".hold_res"}, 64'(result), 64'(e[W-1:0]));
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk({tag, ".hs_rdy"}, 64'(in_ready), 64'd1);
        chk({tag, ".hs_vld"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        out_ready = 1'b0;
        @(posedge clk); #1;
        chk({tag, ".idle"}, 64'(in_ready), 64'd1);
    endtask

    task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input string tag, input int hold);
        @(negedge clk);
        src1 = a; src2 = b; ALU_control = op; in_valid = 1'b1;
        chk({tag, ".in_rdy"}, 64'(in_ready), 64'd1);
        finish_op(op, a, b, tag, hold);
    endtask

    logic [3:0] ops [7];
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    initial begin
        ops = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_NOR, ALU_SLT, 4'b1010};
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        src1 = '0; src2 = '0; ALU_control = '0;
`ifdef ALU_SERIAL_ABORT_EN
        abort = 1'b0;
`endif
        #3;
        chk("rst.in_ready", 64'(in_ready), 64'd1);
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        chk("rst.result", 64'(result), 64'd0);
        chk("rst.zero", 64'(zero), 64'd1);
        chk("rst.cout", 64'(cout), 64'd0);
        chk("rst.ovf", 64'(overflow), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001, "add_ovf", 0);
        do_op(ALU_SUB, 32'h0000_0005, 32'h0000_0005, "sub_eq", 0);
        do_op(ALU_SLT, 32'h8000_0000, 32'h7FFF_FFFF, "slt_ovf", 0);
        do_op(ALU_SLT, 32'h0000_0001, 32'hFFFF_FFFF, "slt_pos", 0);
        do_op(ALU_SLT, 32'hFFFF_FFFE, 32'hFFFF_FFFF, "slt_neg", 0);
        do_op(ALU_NOR, 32'h0F0F_0000, 32'h00FF_00FF, "nor_hold", 5);
        chk("nor.exact", 64'(result), 64'h0000_0000_F000_FF00);
        do_op(4'b1111, 32'hFFFF_FFFF, 32'h1, "illegal", 0);

        // Reset at bit index 10 of an ADD, with the next op's in_valid held across reset release.
        @(negedge clk);
        src1 = 32'h1234; src2 = 32'h4321; ALU_control = ALU_ADD; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        src1 = 32'd3; src2 = 32'd4; ALU_control = ALU_ADD; in_valid = 1'b1;
        #1;
        chk("midrst.out_valid", 64'(out_valid), 64'd0);
        chk("midrst.result", 64'(result), 64'd0);
        chk("midrst.in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        chk("midrst.no_capture", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        finish_op(ALU_ADD, 32'd3, 32'd4, "add_3_4", 0);
        chk("add_3_4.exact", 64'(result), 64'd7);

`ifdef ALU_SERIAL_ABORT_EN
        @(negedge clk);
        src1 = 32'h55; src2 = 32'h22; ALU_control = ALU_ADD; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk); #1;
        chk("abort.in_ready", 64'(in_ready), 64'd1);
        chk("abort.out_valid", 64'(out_valid), 64'd0);
        chk("abort.result", 64'(result), 64'd7);
        @(negedge clk);
        abort = 1'b0;
        repeat (W + 2) begin
            @(posedge clk); #1;
            chk("abort.never_vld", 64'(out_valid), 64'd0);
        end
        do_op(ALU_OR, 32'hA, 32'h5, "or_after_abort", 0);
        chk("or_after_abort.exact", 64'(result), 64'hF);
`endif

        for (int k = 0; k < 40; k++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? ra : 32'($urandom);
            if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
            do_op(ops[$urandom_range(0, 6)], ra, rb, $sformatf("rand%0d", k), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
